// File: rtl/fetch_stage.sv
// ============================================================================
// Module      : fetch_stage
// Description : MIPS instruction-fetch stage with IF/ID pipeline register.
//               Holds a one-word buffer for stalls and a drop state for
//               requests left in flight by a branch redirect.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        PCWrite,
    input  logic        IF_ID_Write,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IF_ID_instrucao,
    output logic [31:0] IF_ID_pcMais4,
    output logic        IF_ID_valido,
    output logic [31:0] pc_atual
);

    localparam logic [31:0] c_WORD_BYTES = 32'd4;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_BUF   = 2'd1,
        ST_DROP  = 2'd2
    } state_t;

    state_t      r_state_q,     w_state_d;
    logic [31:0] r_pc_q,        w_pc_d;
    logic [31:0] r_instr_q,     w_instr_d;
    logic [31:0] r_pc4_q,       w_pc4_d;
    logic        r_valid_q,     w_valid_d;
    logic [31:0] r_buf_instr_q, w_buf_instr_d;
    logic [31:0] r_buf_pc4_q,   w_buf_pc4_d;
    logic [31:0] r_descarte_q,  w_descarte_d;

    logic        w_avanca;
    logic [31:0] w_pc_plus4;

    // A disagreement between the two hazard controls is a stall.
    assign w_avanca   = PCWrite & IF_ID_Write;
    assign w_pc_plus4 = r_pc_q + c_WORD_BYTES;

    assign imem_req  = (r_state_q != ST_BUF) && !reset;
    assign imem_addr = (r_state_q == ST_DROP) ? r_descarte_q : r_pc_q;

    assign IF_ID_instrucao = r_instr_q;
    assign IF_ID_pcMais4   = r_pc4_q;
    assign IF_ID_valido    = r_valid_q;
    assign pc_atual        = r_pc_q;

    always_comb begin
        w_state_d     = r_state_q;
        w_pc_d        = r_pc_q;
        w_instr_d     = r_instr_q;
        w_pc4_d       = r_pc4_q;
        w_valid_d     = r_valid_q;
        w_buf_instr_d = r_buf_instr_q;
        w_buf_pc4_d   = r_buf_pc4_q;
        w_descarte_d  = r_descarte_q;

        if (BranchTaken) begin
            w_pc_d        = BranchTarget;
            w_instr_d     = 32'd0;
            w_pc4_d       = 32'd0;
            w_valid_d     = 1'b0;
            w_buf_instr_d = 32'd0;
            w_buf_pc4_d   = 32'd0;
            case (r_state_q)
                ST_FETCH: begin
                    if (imem_ack) begin
                        w_state_d = ST_FETCH;
                    end else begin
                        // Remember the abandoned address so the handshake stays stable.
                        w_descarte_d = r_pc_q;
                        w_state_d    = ST_DROP;
                    end
                end
                ST_BUF:  w_state_d = ST_FETCH;
                ST_DROP: w_state_d = ST_DROP;
                default: w_state_d = ST_FETCH;
            endcase
        end else begin
            case (r_state_q)
                ST_FETCH: begin
                    if (imem_ack && w_avanca) begin
                        w_instr_d = imem_rdata;
                        w_pc4_d   = w_pc_plus4;
                        w_valid_d = 1'b1;
                        w_pc_d    = w_pc_plus4;
                    end else if (imem_ack) begin
                        w_buf_instr_d = imem_rdata;
                        w_buf_pc4_d   = w_pc_plus4;
                        w_state_d     = ST_BUF;
                    end else if (w_avanca) begin
                        w_instr_d = 32'd0;
                        w_pc4_d   = 32'd0;
                        w_valid_d = 1'b0;
                    end
                end
                ST_BUF: begin
                    if (w_avanca) begin
                        w_instr_d = r_buf_instr_q;
                        w_pc4_d   = r_buf_pc4_q;
                        w_valid_d = 1'b1;
                        w_pc_d    = w_pc_plus4;
                        w_state_d = ST_FETCH;
                    end
                end
                ST_DROP: begin
                    // Nothing usable arrives here; a consumed slot becomes a bubble.
                    if (w_avanca) begin
                        w_instr_d = 32'd0;
                        w_pc4_d   = 32'd0;
                        w_valid_d = 1'b0;
                    end
                    if (imem_ack) begin
                        w_state_d = ST_FETCH;
                    end
                end
                default: w_state_d = ST_FETCH;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state_q     <= ST_FETCH;
            r_pc_q        <= RESET_PC;
            r_instr_q     <= 32'd0;
            r_pc4_q       <= 32'd0;
            r_valid_q     <= 1'b0;
            r_buf_instr_q <= 32'd0;
            r_buf_pc4_q   <= 32'd0;
            r_descarte_q  <= 32'd0;
        end else begin
            r_state_q     <= w_state_d;
            r_pc_q        <= w_pc_d;
            r_instr_q     <= w_instr_d;
            r_pc4_q       <= w_pc4_d;
            r_valid_q     <= w_valid_d;
            r_buf_instr_q <= w_buf_instr_d;
            r_buf_pc4_q   <= w_buf_pc4_d;
            r_descarte_q  <= w_descarte_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================================
// Module      : tb_fetch_stage
// Description : Self-checking bench for fetch_stage using directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_stage;

    logic        clock;
    logic        reset;
    logic        PCWrite;
    logic        IF_ID_Write;
    logic        BranchTaken;
    logic [31:0] BranchTarget;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] IF_ID_instrucao;
    logic [31:0] IF_ID_pcMais4;
    logic        IF_ID_valido;
    logic [31:0] pc_atual;

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clock           (clock),
        .reset           (reset),
        .PCWrite         (PCWrite),
        .IF_ID_Write     (IF_ID_Write),
        .BranchTaken     (BranchTaken),
        .BranchTarget    (BranchTarget),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .IF_ID_instrucao (IF_ID_instrucao),
        .IF_ID_pcMais4   (IF_ID_pcMais4),
        .IF_ID_valido    (IF_ID_valido),
        .pc_atual        (pc_atual)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory model: word = 0x1000_0000 + address, configurable wait cycles.
    logic manual;
    logic ack_man;
    int   mem_wait;
    int   wcnt;

    always_comb begin
        imem_ack = 1'b0;
        if (manual) imem_ack = ack_man;
        else        imem_ack = imem_req && (wcnt >= mem_wait);
    end
    assign imem_rdata = 32'h1000_0000 + imem_addr;

    always @(posedge clock) begin
        if (imem_req && !imem_ack) wcnt <= wcnt + 1;
        else                       wcnt <= 0;
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk_ifid(input string tag, input logic [31:0] ins, input logic [31:0] p4,
                            input logic v);
        chk({tag, " instr"}, IF_ID_instrucao, ins);
        chk({tag, " pc4"},   IF_ID_pcMais4, p4);
        chk({tag, " valid"}, {31'd0, IF_ID_valido}, {31'd0, v});
    endtask

    task automatic chk_req(input string tag, input logic r, input logic [31:0] a);
        chk({tag, " req"}, {31'd0, imem_req}, {31'd0, r});
        if (r) chk({tag, " addr"}, imem_addr, a);
    endtask

    typedef struct {
        logic        pcw;
        logic        ifw;
        logic        br;
        logic [31:0] tgt;
        logic        e_req;
        logic [31:0] e_addr;
        logic [31:0] e_instr;
        logic [31:0] e_pc4;
        logic        e_valid;
        logic [31:0] e_pc;
    } vec_t;

    function automatic vec_t mkv(input logic pcw, input logic ifw, input logic br,
                                 input logic [31:0] tgt, input logic rq, input logic [31:0] ad,
                                 input logic [31:0] ins, input logic [31:0] p4, input logic v,
                                 input logic [31:0] pc);
        vec_t t;
        t.pcw = pcw; t.ifw = ifw; t.br = br; t.tgt = tgt;
        t.e_req = rq; t.e_addr = ad; t.e_instr = ins; t.e_pc4 = p4;
        t.e_valid = v; t.e_pc = pc;
        return t;
    endfunction

    vec_t vecs[18];

    initial begin
        // Zero-wait memory: stream, stalls into BUF, branches from BUF and FETCH, PC wrap.
        vecs[0]  = mkv(1,1,0,0,            1,32'h0,  32'h1000_0000,32'h4,1,32'h4);
        vecs[1]  = mkv(1,1,0,0,            1,32'h4,  32'h1000_0004,32'h8,1,32'h8);
        vecs[2]  = mkv(0,0,0,0,            1,32'h8,  32'h1000_0004,32'h8,1,32'h8);
        vecs[3]  = mkv(0,0,0,0,            0,32'h8,  32'h1000_0004,32'h8,1,32'h8);
        vecs[4]  = mkv(0,0,0,0,            0,32'h8,  32'h1000_0004,32'h8,1,32'h8);
        vecs[5]  = mkv(1,1,0,0,            0,32'h8,  32'h1000_0008,32'hC,1,32'hC);
        vecs[6]  = mkv(1,1,0,0,            1,32'hC,  32'h1000_000C,32'h10,1,32'h10);
        vecs[7]  = mkv(1,0,0,0,            1,32'h10, 32'h1000_000C,32'h10,1,32'h10);
        vecs[8]  = mkv(0,1,0,0,            0,32'h10, 32'h1000_000C,32'h10,1,32'h10);
        vecs[9]  = mkv(1,1,0,0,            0,32'h10, 32'h1000_0010,32'h14,1,32'h14);
        vecs[10] = mkv(0,0,0,0,            1,32'h14, 32'h1000_0010,32'h14,1,32'h14);
        vecs[11] = mkv(0,0,1,32'h40,       0,32'h14, 32'h0,        32'h0, 0,32'h40);
        vecs[12] = mkv(1,1,0,0,            1,32'h40, 32'h1000_0040,32'h44,1,32'h44);
        vecs[13] = mkv(1,1,1,32'h100,      1,32'h44, 32'h0,        32'h0, 0,32'h100);
        vecs[14] = mkv(1,1,0,0,            1,32'h100,32'h1000_0100,32'h104,1,32'h104);
        vecs[15] = mkv(1,1,1,32'hFFFF_FFFC,1,32'h104,32'h0,        32'h0, 0,32'hFFFF_FFFC);
        vecs[16] = mkv(1,1,0,0,            1,32'hFFFF_FFFC,32'h0FFF_FFFC,32'h0,1,32'h0);
        vecs[17] = mkv(1,1,0,0,            1,32'h0,  32'h1000_0000,32'h4,1,32'h4);

        manual = 1'b0; ack_man = 1'b0; mem_wait = 0;
        reset = 1'b1; PCWrite = 1'b1; IF_ID_Write = 1'b1;
        BranchTaken = 1'b0; BranchTarget = 32'd0;

        #1;
        chk("rst req", {31'd0, imem_req}, 32'd0);
        chk("rst pc", pc_atual, 32'h0);
        chk_ifid("rst", 32'h0, 32'h0, 1'b0);
        @(posedge clock); @(posedge clock); #1;
        reset = 1'b0;
        #1;
        chk_req("rel", 1'b1, 32'h0);

        for (int i = 0; i < 18; i++) begin
            PCWrite = vecs[i].pcw; IF_ID_Write = vecs[i].ifw;
            BranchTaken = vecs[i].br; BranchTarget = vecs[i].tgt;
            @(negedge clock);
            chk_req($sformatf("v%0d", i), vecs[i].e_req, vecs[i].e_addr);
            @(posedge clock); #1;
            chk_ifid($sformatf("v%0d", i), vecs[i].e_instr, vecs[i].e_pc4, vecs[i].e_valid);
            chk($sformatf("v%0d pc", i), pc_atual, vecs[i].e_pc);
        end
        PCWrite = 1'b1; IF_ID_Write = 1'b1; BranchTaken = 1'b0;

        // Two wait cycles per word: address held 3 cycles, two bubbles before each word.
        mem_wait = 2;
        for (int w = 0; w < 3; w++) begin
            for (int k = 0; k < 3; k++) begin
                @(negedge clock);
                chk_req($sformatf("ws%0d.%0d", w, k), 1'b1, 32'h4 + 32'(4 * w));
                @(posedge clock); #1;
                if (k < 2) chk_ifid($sformatf("ws%0d.%0d", w, k), 32'h0, 32'h0, 1'b0);
                else chk_ifid($sformatf("ws%0d.%0d", w, k), 32'h1000_0004 + 32'(4 * w),
                              32'h8 + 32'(4 * w), 1'b1);
            end
        end
        chk("ws pc", pc_atual, 32'h10);

        // Redirect with request 0x10 pending; second redirect while in DROP.
        manual = 1'b1; ack_man = 1'b0;
        BranchTaken = 1'b1; BranchTarget = 32'h40;
        @(negedge clock); chk_req("dr1", 1'b1, 32'h10);
        @(posedge clock); #1; BranchTaken = 1'b0;
        chk_ifid("dr1", 32'h0, 32'h0, 1'b0); chk("dr1 pc", pc_atual, 32'h40);
        @(negedge clock); chk_req("dr2", 1'b1, 32'h10);
        @(posedge clock); #1;
        chk_ifid("dr2", 32'h0, 32'h0, 1'b0);
        BranchTaken = 1'b1; BranchTarget = 32'h80;
        @(negedge clock); chk_req("dr3", 1'b1, 32'h10);
        @(posedge clock); #1; BranchTaken = 1'b0;
        chk("dr3 pc", pc_atual, 32'h80);
        ack_man = 1'b1;
        @(negedge clock); chk_req("dr4", 1'b1, 32'h10);
        @(posedge clock); #1;
        chk_ifid("dr4", 32'h0, 32'h0, 1'b0);
        manual = 1'b0; ack_man = 1'b0; mem_wait = 0;
        @(negedge clock); chk_req("dr5", 1'b1, 32'h80);
        @(posedge clock); #1;
        chk_ifid("dr5", 32'h1000_0080, 32'h84, 1'b1);

        // Reset asserted while in DROP.
        manual = 1'b1; ack_man = 1'b0;
        BranchTaken = 1'b1; BranchTarget = 32'h200;
        @(posedge clock); #1; BranchTaken = 1'b0;
        chk("rd pc", pc_atual, 32'h200);
        chk_req("rd drop", 1'b1, 32'h84);
        #2; reset = 1'b1; #1;
        chk("rd pc async", pc_atual, 32'h0);
        chk("rd req async", {31'd0, imem_req}, 32'd0);
        chk_ifid("rd async", 32'h0, 32'h0, 1'b0);
        manual = 1'b0;
        @(posedge clock); #1;
        chk("rd hold req", {31'd0, imem_req}, 32'd0);
        reset = 1'b0; #1;
        chk_req("rd restart", 1'b1, 32'h0);
        @(posedge clock); #1;
        chk_ifid("rd restart", 32'h1000_0000, 32'h4, 1'b1);
        chk("rd restart pc", pc_atual, 32'h4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
